// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard/stall controller: hazard inputs from
// the decode/execute/memory/writeback stages and the stall, flush and forwarding controls returned.
interface hazard_ctrl_if;
  logic [4:0] rs_D, rt_D, rs_E, rt_E;
  logic [4:0] rf_wa_E, rf_wa_M, rf_wa_W;
  logic       we_reg_E, we_reg_M, we_reg_W;
  logic       dm2reg_E, dm2reg_M;
  logic       branch_D, reg_jump_D;
  logic       md_start_E, md_is_div_E;
  logic       dm_ready_M;
  logic       stall_f2d, stall_d2e, flush_d2e, stall_e2m, flush_e2m, flush_m2w;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic       fwd_a_D, fwd_b_D;
  logic       md_busy, md_done;

  modport master (
    output rs_D, rt_D, rs_E, rt_E, rf_wa_E, rf_wa_M, rf_wa_W,
           we_reg_E, we_reg_M, we_reg_W, dm2reg_E, dm2reg_M,
           branch_D, reg_jump_D, md_start_E, md_is_div_E, dm_ready_M,
    input  stall_f2d, stall_d2e, flush_d2e, stall_e2m, flush_e2m, flush_m2w,
           fwd_a_E, fwd_b_E, fwd_a_D, fwd_b_D, md_busy, md_done
  );

  modport slave (
    input  rs_D, rt_D, rs_E, rt_E, rf_wa_E, rf_wa_M, rf_wa_W,
           we_reg_E, we_reg_M, we_reg_W, dm2reg_E, dm2reg_M,
           branch_D, reg_jump_D, md_start_E, md_is_div_E, dm_ready_M,
    output stall_f2d, stall_d2e, flush_d2e, stall_e2m, flush_e2m, flush_m2w,
           fwd_a_E, fwd_b_E, fwd_a_D, fwd_b_D, md_busy, md_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: forwarding selects,
// load-use / branch interlocks, memory-wait freeze and the mult/div busy sequencer.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             done_raw;
  logic             md_stall, lu, bh;
  logic             m_wr, w_wr, e_wr, m_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The counter keeps running during a memory wait; completion waits only for memory.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_raw = 1'b0;
    case (state)
      IDLE: begin
        if (hz.md_start_E && hz.dm_ready_M) begin
          cnt_nx   = hz.md_is_div_E ? DIV_LOAD : MUL_LOAD;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else if (hz.dm_ready_M) begin
          done_raw = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    m_wr     = hz.we_reg_M && (hz.rf_wa_M != 5'd0);
    w_wr     = hz.we_reg_W && (hz.rf_wa_W != 5'd0);
    e_wr     = hz.we_reg_E && (hz.rf_wa_E != 5'd0);
    m_load   = hz.dm2reg_M && (hz.rf_wa_M != 5'd0);
    md_stall = ((state == IDLE) && hz.md_start_E) || ((state == BUSY) && (cnt != '0));
    lu = hz.dm2reg_E && e_wr &&
         ((hz.rf_wa_E == hz.rs_D) || (hz.rf_wa_E == hz.rt_D));
    bh = (hz.branch_D || hz.reg_jump_D) &&
         ((e_wr && ((hz.rf_wa_E == hz.rs_D) || (hz.rf_wa_E == hz.rt_D))) ||
          (m_load && ((hz.rf_wa_M == hz.rs_D) || (hz.rf_wa_M == hz.rt_D))));
  end

  // Every output is held low while reset is asserted.
  always_comb begin
    hz.fwd_a_E   = 2'b00;
    hz.fwd_b_E   = 2'b00;
    hz.fwd_a_D   = 1'b0;
    hz.fwd_b_D   = 1'b0;
    hz.stall_f2d = 1'b0;
    hz.stall_d2e = 1'b0;
    hz.flush_d2e = 1'b0;
    hz.stall_e2m = 1'b0;
    hz.flush_e2m = 1'b0;
    hz.flush_m2w = 1'b0;
    hz.md_busy   = 1'b0;
    hz.md_done   = 1'b0;
    if (!rst) begin
      if (m_wr && (hz.rf_wa_M == hz.rs_E))      hz.fwd_a_E = 2'b10;
      else if (w_wr && (hz.rf_wa_W == hz.rs_E)) hz.fwd_a_E = 2'b01;
      if (m_wr && (hz.rf_wa_M == hz.rt_E))      hz.fwd_b_E = 2'b10;
      else if (w_wr && (hz.rf_wa_W == hz.rt_E)) hz.fwd_b_E = 2'b01;
      hz.fwd_a_D = m_wr && (hz.rf_wa_M == hz.rs_D);
      hz.fwd_b_D = m_wr && (hz.rf_wa_M == hz.rt_D);
      hz.md_busy = (state == BUSY);
      hz.md_done = done_raw;
      if (!hz.dm_ready_M) begin
        hz.stall_f2d = 1'b1;
        hz.stall_d2e = 1'b1;
        hz.stall_e2m = 1'b1;
        hz.flush_m2w = 1'b1;
      end else if (md_stall) begin
        hz.stall_f2d = 1'b1;
        hz.stall_d2e = 1'b1;
        hz.flush_e2m = 1'b1;
      end else if (lu || bh) begin
        hz.stall_f2d = 1'b1;
        hz.flush_d2e = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: forwarding, interlocks, mult/div sequencing,
// memory-wait freeze and reset behaviour, each checked against hand-computed values.
module tb_hazard_ctrl;
  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 32;

  // Control vector: {stall_f2d, stall_d2e, flush_d2e, stall_e2m, flush_e2m, flush_m2w, md_busy, md_done}
  localparam logic [7:0] C_NONE     = 8'h00;
  localparam logic [7:0] C_INTLK    = 8'hA0;
  localparam logic [7:0] C_MD_IDLE  = 8'hC8;
  localparam logic [7:0] C_MD_BUSY  = 8'hCA;
  localparam logic [7:0] C_MEM      = 8'hD4;
  localparam logic [7:0] C_MEM_BUSY = 8'hD6;
  localparam logic [7:0] C_DONE     = 8'h03;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  function automatic logic [7:0] ctrlVec();
    return {hz.stall_f2d, hz.stall_d2e, hz.flush_d2e, hz.stall_e2m,
            hz.flush_e2m, hz.flush_m2w, hz.md_busy, hz.md_done};
  endfunction

  // {fwd_a_E, fwd_b_E, fwd_a_D, fwd_b_D}
  function automatic logic [5:0] fwdVec();
    return {hz.fwd_a_E, hz.fwd_b_E, hz.fwd_a_D, hz.fwd_b_D};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    hz.rs_D = 5'd0; hz.rt_D = 5'd0; hz.rs_E = 5'd0; hz.rt_E = 5'd0;
    hz.rf_wa_E = 5'd0; hz.rf_wa_M = 5'd0; hz.rf_wa_W = 5'd0;
    hz.we_reg_E = 1'b0; hz.we_reg_M = 1'b0; hz.we_reg_W = 1'b0;
    hz.dm2reg_E = 1'b0; hz.dm2reg_M = 1'b0;
    hz.branch_D = 1'b0; hz.reg_jump_D = 1'b0;
    hz.md_start_E = 1'b0; hz.md_is_div_E = 1'b0;
    hz.dm_ready_M = 1'b1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Busy phase of a multiply whose start cycle has already been checked.
  task automatic mulTail(input string tag);
    for (int c = 2; c <= MUL_CYCLES + 2; c++) begin
      nextCycle();
      hz.md_start_E = 1'b0;
      #1;
      checkOutput(tag, ctrlVec(), (c <= MUL_CYCLES) ? C_MD_BUSY :
                                  (c == MUL_CYCLES + 1) ? C_DONE : C_NONE);
    end
  endtask

  initial begin
    applyStimulus();
    rst = 1'b1;

    // Reset dominates even with a pending start, memory wait and a forwarding match
    hz.md_start_E = 1'b1; hz.dm_ready_M = 1'b0;
    hz.rs_E = 5'd5; hz.rf_wa_M = 5'd5; hz.we_reg_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("reset ctrl", ctrlVec(), C_NONE);
      checkOutput("reset fwd", fwdVec(), 6'b0);
    end
    nextCycle();
    applyStimulus();
    rst = 1'b0;
    #1;
    checkOutput("post-reset idle", ctrlVec(), C_NONE);

    // Forwarding
    hz.rs_E = 5'd5; hz.rt_E = 5'd5; hz.rs_D = 5'd5; hz.rt_D = 5'd5;
    hz.rf_wa_M = 5'd5; hz.rf_wa_W = 5'd5; hz.we_reg_M = 1'b1; hz.we_reg_W = 1'b1;
    #1 checkOutput("fwd M beats W", fwdVec(), 6'b10_10_1_1);
    hz.we_reg_M = 1'b0;
    #1 checkOutput("fwd from W", fwdVec(), 6'b01_01_0_0);
    hz.we_reg_M = 1'b1; hz.rf_wa_M = 5'd0; hz.rf_wa_W = 5'd0;
    hz.rs_E = 5'd0; hz.rt_E = 5'd0; hz.rs_D = 5'd0; hz.rt_D = 5'd0;
    #1 checkOutput("fwd r0 never", fwdVec(), 6'b00_00_0_0);
    hz.rs_E = 5'd5; hz.rt_E = 5'd6; hz.rs_D = 5'd6; hz.rt_D = 5'd7;
    hz.rf_wa_M = 5'd6; hz.rf_wa_W = 5'd5;
    #1 checkOutput("fwd mixed", fwdVec(), 6'b01_10_1_0);
    checkOutput("fwd no stall", ctrlVec(), C_NONE);

    // Load-use: one interlock cycle, then the bubble clears it
    nextCycle();
    applyStimulus();
    hz.dm2reg_E = 1'b1; hz.we_reg_E = 1'b1; hz.rf_wa_E = 5'd8; hz.rt_D = 5'd8;
    #1 checkOutput("load-use rt", ctrlVec(), C_INTLK);
    nextCycle();
    hz.dm2reg_E = 1'b0; hz.we_reg_E = 1'b0; hz.rf_wa_E = 5'd0;
    #1 checkOutput("load-use released", ctrlVec(), C_NONE);
    hz.dm2reg_E = 1'b1; hz.we_reg_E = 1'b1; hz.rf_wa_E = 5'd8; hz.rt_D = 5'd0; hz.rs_D = 5'd8;
    #1 checkOutput("load-use rs", ctrlVec(), C_INTLK);
    hz.rf_wa_E = 5'd0; hz.rs_D = 5'd0;
    #1 checkOutput("load-use r0", ctrlVec(), C_NONE);

    // Branch hazards
    applyStimulus();
    hz.branch_D = 1'b1; hz.rs_D = 5'd3; hz.dm2reg_M = 1'b1; hz.rf_wa_M = 5'd3;
    #1 checkOutput("branch vs load M", ctrlVec(), C_INTLK);
    applyStimulus();
    hz.branch_D = 1'b1; hz.rt_D = 5'd4; hz.we_reg_E = 1'b1; hz.rf_wa_E = 5'd4;
    #1 checkOutput("branch vs alu E", ctrlVec(), C_INTLK);
    hz.branch_D = 1'b0;
    #1 checkOutput("no branch no hazard", ctrlVec(), C_NONE);
    hz.reg_jump_D = 1'b1; hz.rt_D = 5'd0; hz.rs_D = 5'd4;
    #1 checkOutput("jr vs alu E", ctrlVec(), C_INTLK);

    // Multiply start wins over a simultaneous load-use
    nextCycle();
    applyStimulus();
    hz.dm2reg_E = 1'b1; hz.we_reg_E = 1'b1; hz.rf_wa_E = 5'd9; hz.rs_D = 5'd9;
    hz.md_start_E = 1'b1;
    #1 checkOutput("mul start", ctrlVec(), C_MD_IDLE);
    hz.dm2reg_E = 1'b0; hz.we_reg_E = 1'b0;
    mulTail("mul seq");

    // Divide, no memory wait
    applyStimulus();
    hz.md_start_E = 1'b1; hz.md_is_div_E = 1'b1;
    #1 checkOutput("div start", ctrlVec(), C_MD_IDLE);
    for (int c = 2; c <= DIV_CYCLES + 2; c++) begin
      nextCycle();
      hz.md_start_E = 1'b0;
      #1;
      checkOutput("div seq", ctrlVec(), (c <= DIV_CYCLES) ? C_MD_BUSY :
                                        (c == DIV_CYCLES + 1) ? C_DONE : C_NONE);
    end

    // Divide with memory not ready for cycles 10..49; start held high to show it is ignored
    hz.md_is_div_E = 1'b1;
    for (int c = 1; c <= 51; c++) begin
      if (c > 1) nextCycle();
      hz.md_start_E = (c <= 50);
      hz.dm_ready_M = !(c >= 10 && c <= 49);
      #1;
      checkOutput("div mem wait", ctrlVec(), (c == 1) ? C_MD_IDLE :
                                             (c < 10) ? C_MD_BUSY :
                                             (c <= 49) ? C_MEM_BUSY :
                                             (c == 50) ? C_DONE : C_NONE);
    end

    // Memory wait in IDLE blocks the start until memory is ready
    nextCycle();
    applyStimulus();
    hz.md_start_E = 1'b1; hz.dm_ready_M = 1'b0;
    #1 checkOutput("idle mem wait", ctrlVec(), C_MEM);
    nextCycle();
    #1 checkOutput("idle mem wait held", ctrlVec(), C_MEM);
    nextCycle();
    hz.dm_ready_M = 1'b1;
    #1 checkOutput("start after mem", ctrlVec(), C_MD_IDLE);
    mulTail("mul after mem");

    // Reset in cycle 3 of a multiply aborts it with no done pulse
    applyStimulus();
    hz.md_start_E = 1'b1;
    #1 checkOutput("abort start", ctrlVec(), C_MD_IDLE);
    nextCycle();
    hz.md_start_E = 1'b0;
    #1 checkOutput("abort busy", ctrlVec(), C_MD_BUSY);
    nextCycle();
    rst = 1'b1;
    #1 checkOutput("abort in reset", ctrlVec(), C_NONE);
    for (int c = 4; c <= 8; c++) begin
      nextCycle();
      rst = 1'b0;
      #1 checkOutput("abort after", ctrlVec(), C_NONE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and stall controller for the 5-stage MIPS pipeline. It generates the stall and flush enables for the fetch/decode, decode/execute and execute/memory pipeline registers, and the forwarding-mux selects for the decode and execute stages. It contains a small FSM and down-counter that hold the pipeline while the multi-cycle multiply/divide unit (which feeds hilo_d) completes. It also freezes the pipeline while data memory reports not-ready.

Parameters:
MUL_CYCLES, 4, multiply latency in cycles; legal range 1..63
DIV_CYCLES, 32, divide latency in cycles; legal range 1..63
CNT_W, 6, width of the busy counter

Ports:
clk  in  1  system clock
rst  in  1  reset
rs_D, rt_D  in  5  decode-stage source registers
rs_E, rt_E  in  5  execute-stage source registers
rf_wa_E, rf_wa_M, rf_wa_W  in  5  destination register per stage
we_reg_E, we_reg_M, we_reg_W  in  1  register-write enable per stage
dm2reg_E, dm2reg_M  in  1  the instruction in that stage is a load
branch_D, reg_jump_D  in  1  decode-stage branch / jr-jalr
md_start_E  in  1  mult/div instruction is in execute
md_is_div_E  in  1  1 = divide, 0 = multiply
dm_ready_M  in  1  data memory can complete this cycle
stall_f2d  out  1  hold PC and fetch/decode register
stall_d2e  out  1  hold decode/execute register
flush_d2e  out  1  load a bubble into decode/execute
stall_e2m  out  1  hold execute/memory register
flush_e2m  out  1  load a bubble into execute/memory
flush_m2w  out  1  load a bubble into memory/writeback
fwd_a_E, fwd_b_E  out  2  execute operand select: 00 register file, 01 writeback, 10 memory
fwd_a_D, fwd_b_D  out  1  decode comparator operand takes the memory-stage alu_out
md_busy  out  1  FSM is in BUSY
md_done  out  1  one-cycle pulse; hilo may be written this cycle

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: state=IDLE, cnt=0. While rst is high, every output is 0.
- Forwarding (combinational):
  - fwd_a_E=10 when we_reg_M && rf_wa_M!=0 && rf_wa_M==rs_E.
  - Otherwise fwd_a_E=01 when the same condition holds for W.
  - Otherwise fwd_a_E=00. M beats W when both match. fwd_b_E uses rt_E identically.
  - fwd_a_D = we_reg_M && rf_wa_M!=0 && rf_wa_M==rs_D. fwd_b_D uses rt_D identically.
  - Register 0 never forwards.
- Load-use hazard (lu): dm2reg_E && we_reg_E && rf_wa_E!=0 && (rf_wa_E==rs_D || rf_wa_E==rt_D).
- Branch hazard (bh): (branch_D || reg_jump_D) and either of:
  - we_reg_E && rf_wa_E!=0 matching rs_D or rt_D;
  - dm2reg_M && rf_wa_M!=0 matching rs_D or rt_D.
- Multiply/divide FSM, states IDLE and BUSY:
  - IDLE, md_start_E && dm_ready_M: load cnt = (md_is_div_E ? DIV_CYCLES : MUL_CYCLES) - 1, go to BUSY.
  - BUSY, cnt!=0: decrement cnt (decrements even while dm_ready_M=0).
  - BUSY, cnt==0 && dm_ready_M: md_done=1, go to IDLE.
  - BUSY, cnt==0 && !dm_ready_M: stay in BUSY, md_done=0.
  - md_start_E is ignored while in BUSY.
  - The mult/div instruction occupies E for exactly N+1 cycles (N = configured latency) when memory is ready.
- md_stall = (IDLE && md_start_E) || (BUSY && cnt!=0).
- Output priority, highest first:
  1. !dm_ready_M: stall_f2d=stall_d2e=stall_e2m=1, flush_m2w=1; all other flushes 0.
  2. md_stall: stall_f2d=stall_d2e=1, flush_e2m=1, stall_e2m=0.
  3. lu || bh: stall_f2d=1, flush_d2e=1, stall_d2e=0.
  4. Otherwise all stall and flush outputs are 0.
- A stall and a flush are never asserted on the same register in the same cycle.
- md_busy = (state==BUSY).
- Reset asserted in BUSY aborts the operation: IDLE and cnt=0 on the next edge, and no md_done pulse.

Test Plan:
- Reset: hold rst 3 cycles with md_start_E=1 and dm_ready_M=0 -> all outputs 0 throughout; md_busy=0 after release with md_start_E=0.
- Forwarding: rs_E=rt_E=5, rf_wa_M=rf_wa_W=5, we_reg_M=we_reg_W=1 -> fwd_a_E=fwd_b_E=10. Drop we_reg_M -> 01. Set all rf_wa=0 -> 00.
- Load-use: dm2reg_E=we_reg_E=1, rf_wa_E=8, rt_D=8 -> stall_f2d=1, flush_d2e=1, stall_d2e=0 for exactly 1 cycle. Same with rf_wa_E=0 -> no stall.
- Multiply, MUL_CYCLES=4: md_start_E=1 pulse from IDLE -> stall_f2d/stall_d2e/flush_e2m high for 4 cycles, md_done high in cycle 5 with stalls low, md_busy high in cycles 2..5. Divide with DIV_CYCLES=32 -> 32 stall cycles, then md_done.
- Memory wait during divide: dm_ready_M=0 for 40 cycles starting at cycle 10 -> stall_e2m=1 and flush_m2w=1 for those cycles. cnt reaches 0 while waiting; md_done appears the first cycle dm_ready_M returns to 1.
- Branch hazard and mid-operation reset: branch_D=1, rs_D=3, dm2reg_M=1, rf_wa_M=3 -> stall_f2d=1, flush_d2e=1. Separately, assert rst in cycle 3 of a multiply -> IDLE next edge, md_done never pulses.
